// File: rtl/tx_deinterleave_pkg.sv
// Shared types and constants for the TX deinterleaver: read FSM states,
// default packet size and the channel-count decode.
package tx_deinterleave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_POP     = 2'd1,
      ST_PRESENT = 2'd2
   } state_e;

   localparam int PKT_WORDS_DEF = 256;

   localparam logic [3:0] CH_N1 = 4'd1;
   localparam logic [3:0] CH_N2 = 4'd2;
   localparam logic [3:0] CH_N4 = 4'd4;
   localparam logic [3:0] CH_N8 = 4'd8;

   // Anything other than 1/2/4/8 falls back to a single channel.
   function automatic logic [3:0] decode_channels(input logic [3:0] ch);
      logic [3:0] n;
      case (ch)
         CH_N1, CH_N2, CH_N4, CH_N8: n = ch;
         default:                    n = CH_N1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// Single-clock 16-bit FIFO with first-word-fall-through output.
// Writes while full are dropped; level_next_o exposes the level after this edge.
module tx_word_fifo
   import tx_deinterleave_pkg::*;
#(
   parameter int DEPTH = 512,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en_i,
   input  logic [15:0]   wr_data_i,
   input  logic          rd_en_i,
   output logic [15:0]   rd_data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o,
   output logic [LW-1:0] level_next_o
);

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          push, pop;

   assign full_o       = (level_q == LW'(DEPTH));
   assign empty_o      = (level_q == '0);
   assign push         = wr_en_i && !full_o;
   assign pop          = rd_en_i && !empty_o;
   assign rd_data_o    = mem[rd_ptr_q];
   assign level_o      = level_q;
   assign level_next_o = level_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/tx_deinterleave.sv
// Buffers interleaved USB words and, on each DSP strobe, pops N words into
// per-channel staging and presents them on ch_0..ch_7 with a tx_valid pulse.
module tx_deinterleave
   import tx_deinterleave_pkg::*;
#(
   parameter int DEPTH     = 512,
   parameter int PKT_WORDS = PKT_WORDS_DEF,
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          WR,
   input  logic [15:0]   usbdata,
   input  logic [3:0]    channels,
   input  logic          txstrobe,
   input  logic          clear_status,
   output logic [15:0]   ch_0,
   output logic [15:0]   ch_1,
   output logic [15:0]   ch_2,
   output logic [15:0]   ch_3,
   output logic [15:0]   ch_4,
   output logic [15:0]   ch_5,
   output logic [15:0]   ch_6,
   output logic [15:0]   ch_7,
   output logic          tx_valid,
   output logic          have_space,
   output logic          underrun,
   output logic          overrun,
   output logic [LW-1:0] level
);

   state_e        state_q, state_d;
   logic [3:0]    n_q, n_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [15:0]   stage_q [8];
   logic [15:0]   stage_d [8];
   logic [15:0]   ch_q [8];
   logic [15:0]   ch_d [8];
   logic          tx_valid_q, tx_valid_d;
   logic          underrun_q, underrun_d;
   logic          overrun_q, overrun_d;
   logic          have_space_q, have_space_d;
   logic          pop, underrun_set;
   logic [15:0]   fifo_data;
   logic          fifo_full, fifo_empty;
   logic [LW-1:0] fifo_level, fifo_level_next;

   tx_word_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en_i      (WR),
      .wr_data_i    (usbdata),
      .rd_en_i      (pop),
      .rd_data_o    (fifo_data),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .level_o      (fifo_level),
      .level_next_o (fifo_level_next)
   );

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      cnt_d        = cnt_q;
      stage_d      = stage_q;
      ch_d         = ch_q;
      tx_valid_d   = 1'b0;
      pop          = 1'b0;
      underrun_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (txstrobe) begin
               n_d = decode_channels(channels);
               if (!fifo_empty && fifo_level >= LW'(n_d)) begin
                  state_d = ST_POP;
                  cnt_d   = '0;
               end else begin
                  underrun_set = 1'b1;
                  tx_valid_d   = 1'b1;
                  for (int k = 0; k < 8; k++) ch_d[k] = '0;
               end
            end
         end
         ST_POP: begin
            pop            = 1'b1;
            stage_d[cnt_q] = fifo_data;
            cnt_d          = cnt_q + 3'd1;
            // Outputs load on the last pop so tx_valid is high during PRESENT.
            if ({1'b0, cnt_q} == n_q - 4'd1) begin
               state_d    = ST_PRESENT;
               tx_valid_d = 1'b1;
               for (int k = 0; k < 8; k++)
                  ch_d[k] = (k < int'(n_q)) ? stage_d[k] : 16'h0000;
            end
         end
         ST_PRESENT: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Sticky flags: a set event wins over a simultaneous clear.
   assign underrun_d   = underrun_set | (underrun_q & ~clear_status);
   assign overrun_d    = (WR & fifo_full) | (overrun_q & ~clear_status);
   assign have_space_d = (DEPTH - int'(fifo_level_next)) >= PKT_WORDS;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         n_q          <= CH_N1;
         cnt_q        <= '0;
         tx_valid_q   <= 1'b0;
         underrun_q   <= 1'b0;
         overrun_q    <= 1'b0;
         have_space_q <= 1'b1;
         for (int k = 0; k < 8; k++) begin
            stage_q[k] <= '0;
            ch_q[k]    <= '0;
         end
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         cnt_q        <= cnt_d;
         tx_valid_q   <= tx_valid_d;
         underrun_q   <= underrun_d;
         overrun_q    <= overrun_d;
         have_space_q <= have_space_d;
         stage_q      <= stage_d;
         ch_q         <= ch_d;
      end
   end

   assign ch_0       = ch_q[0];
   assign ch_1       = ch_q[1];
   assign ch_2       = ch_q[2];
   assign ch_3       = ch_q[3];
   assign ch_4       = ch_q[4];
   assign ch_5       = ch_q[5];
   assign ch_6       = ch_q[6];
   assign ch_7       = ch_q[7];
   assign tx_valid   = tx_valid_q;
   assign have_space = have_space_q;
   assign underrun   = underrun_q;
   assign overrun    = overrun_q;
   assign level      = fifo_level;

endmodule

// File: tb/tb_tx_deinterleave.sv
// Directed bench for tx_deinterleave: vector table for the channel decode
// plus hand-written sequences for fill/drain, flags, reset and mid-burst cases.
module tb_tx_deinterleave;

   logic        clk = 1'b0;
   logic        reset_n, WR, txstrobe, clear_status;
   logic [15:0] usbdata;
   logic [3:0]  channels;
   logic [15:0] ch_0, ch_1, ch_2, ch_3, ch_4, ch_5, ch_6, ch_7;
   logic [15:0] ch_o [8];
   logic        tx_valid, have_space, underrun, overrun;
   logic [9:0]  level;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tx_deinterleave #(.DEPTH(512), .PKT_WORDS(256)) dut (
      .clk(clk), .reset_n(reset_n), .WR(WR), .usbdata(usbdata),
      .channels(channels), .txstrobe(txstrobe), .clear_status(clear_status),
      .ch_0(ch_0), .ch_1(ch_1), .ch_2(ch_2), .ch_3(ch_3),
      .ch_4(ch_4), .ch_5(ch_5), .ch_6(ch_6), .ch_7(ch_7),
      .tx_valid(tx_valid), .have_space(have_space), .underrun(underrun),
      .overrun(overrun), .level(level)
   );

   always_comb begin
      ch_o[0] = ch_0; ch_o[1] = ch_1; ch_o[2] = ch_2; ch_o[3] = ch_3;
      ch_o[4] = ch_4; ch_o[5] = ch_5; ch_o[6] = ch_6; ch_o[7] = ch_7;
   end

   typedef struct {
      logic [3:0]  chans;
      logic [15:0] base;
      int          exp_n;
      int          exp_lat;
   } vec_t;

   vec_t vecs [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic write_word(input logic [15:0] d);
      WR = 1'b1;
      usbdata = d;
      step();
      WR = 1'b0;
   endtask

   // Strobe for one cycle, then wait (bounded) for tx_valid; lat counts edges.
   task automatic do_strobe(output int lat);
      txstrobe = 1'b1;
      step();
      txstrobe = 1'b0;
      lat = 1;
      while (tx_valid !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int bad;
      logic [15:0] exp;

      vecs[0] = '{chans: 4'd1,  base: 16'h0100, exp_n: 1, exp_lat: 2};
      vecs[1] = '{chans: 4'd2,  base: 16'h0200, exp_n: 2, exp_lat: 3};
      vecs[2] = '{chans: 4'd4,  base: 16'h0300, exp_n: 4, exp_lat: 5};
      vecs[3] = '{chans: 4'd8,  base: 16'h0400, exp_n: 8, exp_lat: 9};
      vecs[4] = '{chans: 4'd3,  base: 16'h0500, exp_n: 1, exp_lat: 2};
      vecs[5] = '{chans: 4'd15, base: 16'h0600, exp_n: 1, exp_lat: 2};

      WR = 1'b0; usbdata = '0; channels = 4'd1; txstrobe = 1'b0; clear_status = 1'b0;
      do_reset();

      // Reset state
      check("rst_level", 32'(level), 32'd0);
      check("rst_valid", 32'(tx_valid), 32'd0);
      check("rst_flags", {30'd0, underrun, overrun}, 32'd0);
      check("rst_space", 32'(have_space), 32'd1);
      bad = 0;
      for (int k = 0; k < 8; k++) if (ch_o[k] !== 16'h0) bad++;
      check("rst_ch_zero", 32'(bad), 32'd0);

      // Vector table: channel decode, latency, unused channels zero
      for (int v = 0; v < 6; v++) begin
         channels = vecs[v].chans;
         for (int w = 0; w < vecs[v].exp_n; w++) write_word(vecs[v].base + 16'(w));
         do_strobe(lat);
         check($sformatf("tbl%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
         for (int k = 0; k < 8; k++) begin
            exp = (k < vecs[v].exp_n) ? vecs[v].base + 16'(k) : 16'h0000;
            check($sformatf("tbl%0d_ch%0d", v, k), 32'(ch_o[k]), 32'(exp));
         end
         step();
         check($sformatf("tbl%0d_pulse", v), 32'(tx_valid), 32'd0);
         check($sformatf("tbl%0d_level", v), 32'(level), 32'd0);
      end

      // Single channel: 256 words, 256 strobes every 4 cycles
      channels = 4'd1;
      for (int i = 0; i < 256; i++) write_word(16'(i));
      check("seq_level_full", 32'(level), 32'd256);
      check("seq_space_256", 32'(have_space), 32'd1);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         do_strobe(lat);
         check("seq_lat", 32'(lat), 32'd2);
         check("seq_ch0", 32'(ch_o[0]), 32'(i));
         for (int k = 1; k < 8; k++) if (ch_o[k] !== 16'h0) bad++;
         step();
         step();
      end
      check("seq_others_zero", 32'(bad), 32'd0);
      check("seq_flags", {30'd0, underrun, overrun}, 32'd0);
      check("seq_level_end", 32'(level), 32'd0);

      // Four channels, two bursts
      channels = 4'd4;
      for (int i = 0; i < 8; i++) write_word(16'h0010 + 16'(i));
      do_strobe(lat);
      check("c4a_lat", 32'(lat), 32'd5);
      for (int k = 0; k < 4; k++) check("c4a_ch", 32'(ch_o[k]), 32'h10 + 32'(k));
      for (int k = 4; k < 8; k++) check("c4a_unused", 32'(ch_o[k]), 32'd0);
      step();
      do_strobe(lat);
      check("c4b_lat", 32'(lat), 32'd5);
      for (int k = 0; k < 4; k++) check("c4b_ch", 32'(ch_o[k]), 32'h14 + 32'(k));
      check("c4b_level", 32'(level), 32'd0);
      step();

      // Underrun on empty buffer (ch_* still hold 0x14..0x17 here)
      channels = 4'd2;
      do_strobe(lat);
      check("und_lat", 32'(lat), 32'd1);
      check("und_flag", 32'(underrun), 32'd1);
      bad = 0;
      for (int k = 0; k < 8; k++) if (ch_o[k] !== 16'h0) bad++;
      check("und_ch_zero", 32'(bad), 32'd0);
      step();
      check("und_pulse", 32'(tx_valid), 32'd0);
      step();
      check("und_sticky", 32'(underrun), 32'd1);
      clear_status = 1'b1;
      step();
      clear_status = 1'b0;
      check("und_cleared", 32'(underrun), 32'd0);
      clear_status = 1'b1;
      do_strobe(lat);
      clear_status = 1'b0;
      check("und_set_beats_clear", 32'(underrun), 32'd1);
      step();
      clear_status = 1'b1;
      step();
      clear_status = 1'b0;

      // Fill to capacity, overrun, then drain in bursts of 8
      do_reset();
      for (int i = 0; i < 512; i++) begin
         write_word(16'(i));
         if (i == 255) check("fill_space_256", 32'(have_space), 32'd1);
         if (i == 256) check("fill_space_257", 32'(have_space), 32'd0);
      end
      check("fill_level", 32'(level), 32'd512);
      check("fill_no_ovr", 32'(overrun), 32'd0);
      write_word(16'hBEEF);
      check("ovr_flag", 32'(overrun), 32'd1);
      check("ovr_level", 32'(level), 32'd512);
      channels = 4'd8;
      for (int b = 0; b < 64; b++) begin
         do_strobe(lat);
         check("drain_ch0", 32'(ch_o[0]), 32'(8 * b));
         if (b == 30) begin
            check("drain_level_264", 32'(level), 32'd264);
            check("drain_space_264", 32'(have_space), 32'd0);
         end
         if (b == 31) begin
            check("drain_level_256", 32'(level), 32'd256);
            check("drain_space_256", 32'(have_space), 32'd1);
         end
         if (b == 63) check("drain_last_ch7", 32'(ch_o[7]), 32'h01FF);
         step();
      end
      check("drain_level_end", 32'(level), 32'd0);
      check("drain_ovr_sticky", 32'(overrun), 32'd1);
      check("drain_no_und", 32'(underrun), 32'd0);
      clear_status = 1'b1;
      step();
      clear_status = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'd0);

      // Reset during the third POP cycle of an 8-channel burst
      for (int i = 0; i < 8; i++) write_word(16'h0A00 + 16'(i));
      txstrobe = 1'b1;
      step();
      txstrobe = 1'b0;
      step();
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (tx_valid !== 1'b0) bad++;
         step();
      end
      check("rpop_no_valid", 32'(bad), 32'd0);
      check("rpop_level", 32'(level), 32'd0);
      check("rpop_space", 32'(have_space), 32'd1);
      bad = 0;
      for (int k = 0; k < 8; k++) if (ch_o[k] !== 16'h0) bad++;
      check("rpop_ch_zero", 32'(bad), 32'd0);
      channels = 4'd1;
      do_strobe(lat);
      check("rpop_idle_lat", 32'(lat), 32'd1);
      check("rpop_idle_und", 32'(underrun), 32'd1);
      step();

      // Concurrent write+pop at level 100; channels change mid-burst; strobes in POP ignored
      do_reset();
      channels = 4'd2;
      for (int i = 0; i < 100; i++) write_word(16'h1000 + 16'(i));
      txstrobe = 1'b1;
      step();
      channels = 4'd4;
      WR = 1'b1;
      usbdata = 16'h2000;
      step();
      usbdata = 16'h2001;
      step();
      WR = 1'b0;
      txstrobe = 1'b0;
      check("mix_valid", 32'(tx_valid), 32'd1);
      check("mix_level", 32'(level), 32'd100);
      check("mix_ch0", 32'(ch_o[0]), 32'h1000);
      check("mix_ch1", 32'(ch_o[1]), 32'h1001);
      check("mix_ch2", 32'(ch_o[2]), 32'd0);
      check("mix_ch3", 32'(ch_o[3]), 32'd0);
      step();
      check("mix_no_und", 32'(underrun), 32'd0);
      do_strobe(lat);
      check("mix_next_lat", 32'(lat), 32'd5);
      check("mix_next_ch0", 32'(ch_o[0]), 32'h1002);
      check("mix_next_ch3", 32'(ch_o[3]), 32'h1005);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
